// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared encodings, FSM states and condition evaluation for the issue unit
package issue_pkg;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_DISPATCH} state_t;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0, OP_STORE = 4'd1, OP_MOV = 4'd2, OP_MOVL = 4'd3,
    OP_MOVH = 4'd4, OP_RDFLAGS = 4'd5, OP_JUMP = 4'd6
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_ADC = 4'd1, ALU_SUB = 4'd2, ALU_SBC = 4'd3,
    ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOT = 4'd7,
    ALU_SHL = 4'd8, ALU_SHR = 4'd9, ALU_CMP = 4'd10
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_GT, COND_LT, COND_GE, COND_LE, COND_CS, COND_CC,
    COND_MI, COND_PL, COND_AL, COND_NV, COND_VS, COND_VC, COND_HI, COND_LS
  } cond_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 2;
  localparam int FLAG_Z = 3;

  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] flags);
    logic c, s, o, z;
    c = flags[FLAG_C];
    s = flags[FLAG_S];
    o = flags[FLAG_O];
    z = flags[FLAG_Z];
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_GT: return !z && (s == o);
      COND_LT: return s != o;
      COND_GE: return s == o;
      COND_LE: return z || (s != o);
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return s;
      COND_PL: return !s;
      COND_AL: return 1'b1;
      COND_NV: return 1'b0;
      COND_VS: return o;
      COND_VC: return !o;
      COND_HI: return c && !z;
      default: return !c || z;
    endcase
  endfunction

endpackage

// File: rtl/instr_issue_unit_if.sv
// rtl/instr_issue_unit_if.sv - instruction fetch, core dispatch and data memory bus
interface instr_issue_unit_if #(
  parameter int WIDTH     = 16,
  parameter int NUM_CORES = 4
);
  logic [WIDTH-1:0]     rom_addr;
  logic [15:0]          rom_data;
  logic                 rom_valid;
  logic [14:0]          core_instr;
  logic [NUM_CORES-1:0] core_valid;
  logic [NUM_CORES-1:0] core_ready;
  logic                 mem_req;
  logic                 mem_we;
  logic [WIDTH-1:0]     mem_addr;
  logic [WIDTH-1:0]     mem_wdata;
  logic                 mem_ack;
  logic [WIDTH-1:0]     mem_rdata;

  modport master (
    output rom_addr, input rom_data, input rom_valid,
    output core_instr, output core_valid, input core_ready,
    output mem_req, output mem_we, output mem_addr, output mem_wdata,
    input mem_ack, input mem_rdata
  );

  modport slave (
    input rom_addr, output rom_data, output rom_valid,
    input core_instr, input core_valid, output core_ready,
    input mem_req, input mem_we, input mem_addr, input mem_wdata,
    output mem_ack, output mem_rdata
  );
endinterface

// File: rtl/issue_alu.sv
// rtl/issue_alu.sv - combinational ALU; C is carry out for adds and borrow out for subtracts
module issue_alu
  import issue_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             s,
  output logic             o,
  output logic             z
);
  logic [WIDTH:0] ext_a, ext_b, ext_cin, ext;

  assign ext_a   = {1'b0, a};
  assign ext_b   = {1'b0, b};
  assign ext_cin = {{WIDTH{1'b0}}, cin};

  always_comb begin
    ext    = '0;
    result = a;
    c      = 1'b0;
    o      = 1'b0;
    case (op)
      ALU_ADD, ALU_ADC: begin
        ext    = ext_a + ext_b + ((op == ALU_ADC) ? ext_cin : '0);
        result = ext[WIDTH-1:0];
        c      = ext[WIDTH];
        o      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB, ALU_SBC, ALU_CMP: begin
        ext    = ext_a - ext_b - ((op == ALU_SBC) ? ext_cin : '0);
        result = ext[WIDTH-1:0];
        c      = ext[WIDTH];
        o      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_SHL: begin
        result = a << 1;
        c      = a[WIDTH-1];
      end
      ALU_SHR: begin
        result = a >> 1;
        c      = a[0];
      end
      default: ;
    endcase
    s = result[WIDTH-1];
    z = (result == '0);
  end
endmodule

// File: rtl/instr_issue_unit.sv
// rtl/instr_issue_unit.sv - fetch/exec/mem/dispatch sequencer with register file and flags
module instr_issue_unit
  import issue_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int          NUM_CORES = 4,
  parameter logic [14:0] NOP       = 15'b1_0000_1011_00_00_00
) (
  input  logic                 clock,
  input  logic                 reset_n,
  instr_issue_unit_if.master   bus,
  input  logic                 reg_we,
  input  logic [2:0]           reg_sel,
  input  logic [WIDTH-1:0]     reg_wdata,
  output logic [3:0]           flags_out
);
  state_t               state, state_next;
  logic [WIDTH-1:0]     regs [8];
  logic [3:0]           flags;
  logic [15:0]          ir;
  logic [NUM_CORES-1:0] pending, lanes_left;

  logic [3:0]       op, cond;
  logic [2:0]       a_idx, b_idx, imm_idx;
  logic [7:0]       imm;
  logic             cond_ok, is_mem, alu_taken, lanes_done, retire;
  logic [WIDTH-1:0] alu_result;
  logic             alu_c, alu_s, alu_o, alu_z;
  logic             wr_en, flags_we;
  logic [2:0]       wr_idx;
  logic [WIDTH-1:0] wr_data;

  assign op         = ir[13:10];
  assign cond       = ir[9:6];
  assign a_idx      = ir[5:3];
  assign b_idx      = ir[2:0];
  assign imm_idx    = ir[11:9];
  assign imm        = ir[8:1];
  assign cond_ok    = cond_true(cond, flags);
  assign is_mem     = !ir[15] && !ir[14] && ((op == OP_LOAD) || (op == OP_STORE));
  assign alu_taken  = cond_ok && (op <= ALU_CMP);
  assign lanes_left = pending & ~bus.core_ready;
  assign lanes_done = (lanes_left == '0);
  assign retire     = (state != ST_FETCH) && (state_next == ST_FETCH);
  assign flags_out  = flags;

  issue_alu #(.WIDTH(WIDTH)) u_alu (
    .a(regs[a_idx]), .b(regs[b_idx]), .op(op), .cin(flags[FLAG_C]),
    .result(alu_result), .c(alu_c), .s(alu_s), .o(alu_o), .z(alu_z)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: if (bus.rom_valid) state_next = ST_EXEC;
      ST_EXEC: begin
        if (ir[15])                 state_next = ST_DISPATCH;
        else if (is_mem && cond_ok) state_next = ST_MEM;
        else                        state_next = ST_FETCH;
      end
      ST_MEM:      if (bus.mem_ack) state_next = ST_FETCH;
      ST_DISPATCH: if (lanes_done)  state_next = ST_FETCH;
      default:     state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    bus.rom_addr   = regs[7];
    bus.core_instr = (state == ST_DISPATCH) ? ir[14:0] : NOP;
    bus.core_valid = (state == ST_DISPATCH) ? pending : '0;
    bus.mem_req    = (state == ST_MEM);
    bus.mem_we     = (state == ST_MEM) && (op == OP_STORE);
    bus.mem_addr   = regs[b_idx];
    bus.mem_wdata  = regs[a_idx];
  end

  // Register write selected by the retiring instruction; only applied on retire.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = a_idx;
    wr_data  = alu_result;
    flags_we = 1'b0;
    if (state == ST_EXEC && !ir[15]) begin
      if (ir[14]) begin
        flags_we = alu_taken;
        wr_en    = alu_taken && (op != ALU_CMP);
      end else begin
        case (op)
          OP_MOV: begin
            wr_en   = cond_ok;
            wr_data = regs[b_idx];
          end
          OP_MOVL: begin
            wr_en   = imm_idx < 3'd6;
            wr_idx  = imm_idx;
            wr_data = (regs[imm_idx] & ~WIDTH'(16'h00FF)) | WIDTH'(imm);
          end
          OP_MOVH: begin
            wr_en   = imm_idx < 3'd6;
            wr_idx  = imm_idx;
            wr_data = (regs[imm_idx] & ~WIDTH'(16'hFF00)) | (WIDTH'(imm) << 8);
          end
          OP_RDFLAGS: begin
            wr_en   = cond_ok;
            wr_data = WIDTH'(flags);
          end
          OP_JUMP: begin
            wr_en   = cond_ok;
            wr_idx  = 3'd7;
            wr_data = regs[a_idx];
          end
          default: ;
        endcase
      end
    end else if (state == ST_MEM && bus.mem_ack && op == OP_LOAD) begin
      wr_en   = 1'b1;
      wr_data = bus.mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      regs    <= '{default: '0};
      flags   <= '0;
      ir      <= '0;
      pending <= '0;
    end else begin
      if (state == ST_FETCH && bus.rom_valid) ir <= bus.rom_data;
      if (flags_we) flags <= {alu_z, alu_o, alu_s, alu_c};
      if (state == ST_EXEC && ir[15]) pending <= '1;
      else if (state == ST_DISPATCH)  pending <= lanes_left;
      if (retire) begin
        if (wr_en) regs[wr_idx] <= wr_data;
        if (!(wr_en && wr_idx == 3'd7)) regs[7] <= regs[7] + WIDTH'(1);
      end
      // Placed last so an external write beats a same-cycle retire write.
      if (reg_we) regs[reg_sel] <= reg_wdata;
    end
  end
endmodule
